// File: rtl/io_unit_pkg.sv
// Shared types for the byte I/O execution unit: opcodes, queue entry, FSM states.
package io_unit_pkg;

  localparam int unsigned RSV_ID_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned INSTR_W  = 6;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_IN  = 6'h10;
  localparam logic [INSTR_W-1:0] I_OUT = 6'h11;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   value;
  } cdb_t;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rob_id;
    logic [INSTR_W-1:0]  opcode;
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   value;
  } io_req_t;

  // Only the low byte of an operand ever reaches the port, so entries keep just that.
  typedef struct packed {
    logic [RSV_ID_W-1:0] rob_id;
    logic [INSTR_W-1:0]  opcode;
    logic [RSV_ID_W-1:0] tag;
    logic [BYTE_W-1:0]   value;
    logic                filled;
  } io_entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, BCAST} io_state_t;

  function automatic logic is_io_op(input logic [INSTR_W-1:0] op);
    return (op == I_IN) || (op == I_OUT);
  endfunction

endpackage

// File: rtl/io_unit_if.sv
// Dispatch, ROB, CDB and byte-port signals of the I/O unit.
interface io_unit_if;
  import io_unit_pkg::*;

  logic                i_valid;
  io_req_t             i_data;
  logic                i_filled;
  logic                i_ready;
  logic [RSV_ID_W-1:0] rob_head;
  logic                rob_head_valid;
  cdb_t                cdb;
  logic                cdb_valid;
  cdb_t                o_cdb;
  logic                o_valid;
  logic                o_ready;
  logic [BYTE_W-1:0]   io_o_data;
  logic                io_o_valid;
  logic                io_o_ready;
  logic [BYTE_W-1:0]   io_i_data;
  logic                io_i_valid;
  logic                io_i_ready;

  modport slave (
    input  i_valid, i_data, i_filled, rob_head, rob_head_valid, cdb, cdb_valid,
           o_ready, io_o_ready, io_i_data, io_i_valid,
    output i_ready, o_cdb, o_valid, io_o_data, io_o_valid, io_i_ready
  );

  modport master (
    output i_valid, i_data, i_filled, rob_head, rob_head_valid, cdb, cdb_valid,
           o_ready, io_o_ready, io_i_data, io_i_valid,
    input  i_ready, o_cdb, o_valid, io_o_data, io_o_valid, io_i_ready
  );

endinterface

// File: rtl/io_queue.sv
// In-order circular buffer of pending I/O ops; unfilled entries snoop the CDB.
module io_queue
  import io_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                push_i,
  input  io_entry_t           push_entry_i,
  input  logic                pop_i,
  input  logic                snoop_valid_i,
  input  logic [RSV_ID_W-1:0] snoop_tag_i,
  input  logic [BYTE_W-1:0]   snoop_byte_i,
  output logic [RSV_ID_W-1:0] head_rob_id_o,
  output logic                head_is_out_o,
  output logic [BYTE_W-1:0]   head_value_o,
  output logic                head_filled_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                ready_o
);

  io_entry_t          mem_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q;
  io_entry_t          push_fill;

  // A broadcast landing on the dispatch cycle fills the entry as it is written.
  always_comb begin
    push_fill = push_entry_i;
    if (!push_entry_i.filled && snoop_valid_i && (snoop_tag_i == push_entry_i.tag)) begin
      push_fill.value  = snoop_byte_i;
      push_fill.filled = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      vld_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PTR_W'(i)] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (vld_q[PTR_W'(i)] && !mem_q[PTR_W'(i)].filled && snoop_valid_i &&
            (mem_q[PTR_W'(i)].tag == snoop_tag_i)) begin
          mem_q[PTR_W'(i)].value  <= snoop_byte_i;
          mem_q[PTR_W'(i)].filled <= 1'b1;
        end
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_fill;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

  assign head_rob_id_o = mem_q[rd_ptr_q].rob_id;
  assign head_is_out_o = (mem_q[rd_ptr_q].opcode == I_OUT);
  assign head_value_o  = mem_q[rd_ptr_q].value;
  assign head_filled_o = mem_q[rd_ptr_q].filled;
  assign count_o       = count_q;
  assign ready_o       = ready_q;

endmodule

// File: rtl/io_unit.sv
// Byte I/O execution unit: runs the queue head through the io handshake once it is ROB head.
module io_unit
  import io_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic      clk,
  input logic      nrst,
  io_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  io_state_t           state_q;
  io_entry_t           push_entry;
  logic [RSV_ID_W-1:0] head_rob_id;
  logic                head_is_out, head_filled;
  logic [BYTE_W-1:0]   head_value;
  logic [CNT_W-1:0]    count;
  logic                queue_ready, push_c, pop_c, head_go_c;
  logic                io_o_valid_q, io_i_ready_q, o_valid_q;
  logic [BYTE_W-1:0]   io_o_data_q;
  cdb_t                o_cdb_q;

  assign push_entry = '{rob_id: bus.i_data.rob_id, opcode: bus.i_data.opcode,
                        tag: bus.i_data.tag, value: bus.i_data.value[BYTE_W-1:0],
                        filled: bus.i_filled};
  assign push_c     = bus.i_valid && queue_ready && is_io_op(bus.i_data.opcode);
  assign pop_c      = (state_q == BCAST) && bus.o_ready;
  // I_IN needs no operand; I_OUT waits for its byte to be filled.
  assign head_go_c  = bus.rob_head_valid && (bus.rob_head == head_rob_id) &&
                      (!head_is_out || head_filled);

  io_queue #(.DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .nrst          (nrst),
    .push_i        (push_c),
    .push_entry_i  (push_entry),
    .pop_i         (pop_c),
    .snoop_valid_i (bus.cdb_valid),
    .snoop_tag_i   (bus.cdb.tag),
    .snoop_byte_i  (bus.cdb.value[BYTE_W-1:0]),
    .head_rob_id_o (head_rob_id),
    .head_is_out_o (head_is_out),
    .head_value_o  (head_value),
    .head_filled_o (head_filled),
    .count_o       (count),
    .ready_o       (queue_ready)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      io_o_valid_q <= 1'b0;
      io_o_data_q  <= '0;
      io_i_ready_q <= 1'b0;
      o_valid_q    <= 1'b0;
      o_cdb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (count != '0) state_q <= WAIT;
        WAIT: begin
          if (head_go_c) begin
            state_q <= XFER;
            if (head_is_out) begin
              io_o_valid_q <= 1'b1;
              io_o_data_q  <= head_value;
            end else begin
              io_i_ready_q <= 1'b1;
            end
          end
        end
        XFER: begin
          if (io_o_valid_q && bus.io_o_ready) begin
            io_o_valid_q <= 1'b0;
            o_valid_q    <= 1'b1;
            o_cdb_q      <= '{tag: head_rob_id, value: '0};
            state_q      <= BCAST;
          end else if (io_i_ready_q && bus.io_i_valid) begin
            io_i_ready_q <= 1'b0;
            o_valid_q    <= 1'b1;
            o_cdb_q      <= '{tag: head_rob_id, value: DATA_W'(bus.io_i_data)};
            state_q      <= BCAST;
          end
        end
        BCAST: begin
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= ((count == CNT_W'(1)) && !push_c) ? IDLE : WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ready    = queue_ready;
  assign bus.io_o_valid = io_o_valid_q;
  assign bus.io_o_data  = io_o_data_q;
  assign bus.io_i_ready = io_i_ready_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_cdb      = o_cdb_q;

endmodule

// File: doc/io_unit.md
Name: io_unit

Overview:
- In-order execution unit for byte I/O instructions (I_IN, I_OUT); sits beside alu, downstream of core dispatch.
- Buffers dispatched ops in a small in-order queue and snoops the CDB for pending operands.
- Drives the core io_o/io_i byte handshakes, then broadcasts completion on the CDB to the reorder buffer.
- Side effects occur only when the op is the ROB head, so I/O is never speculative.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- RSV_ID_W, 4, reservation/ROB tag width
- DATA_W, 32, data width
- INSTR_W, 6, opcode width

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- i_valid  in  1  dispatch request
- i_data  in  2*RSV_ID_W+INSTR_W+DATA_W  {rob_id, opcode, operand{tag,value}}
- i_filled  in  1  operand value valid (else tag pending)
- i_ready  out  1  queue not full
- rob_head  in  RSV_ID_W  rsv_id of oldest uncommitted ROB entry
- rob_head_valid  in  1  ROB non-empty
- cdb  in  RSV_ID_W+DATA_W  {tag, value} broadcast
- cdb_valid  in  1  cdb qualifier
- o_cdb  out  RSV_ID_W+DATA_W  result {rob_id, value}
- o_valid  out  1  result request
- o_ready  in  1  CDB grant
- io_o_data  out  8  output byte
- io_o_valid  out  1
- io_o_ready  in  1
- io_i_data  in  8  input byte
- io_i_valid  in  1
- io_i_ready  out  1

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (nrst).
- Reset: queue empty, FSM=IDLE. All outputs 0 except i_ready=1.
- Enqueue: occurs when i_valid && i_ready. Ops other than I_IN/I_OUT are ignored (not enqueued).
  - Entry stores rob_id, opcode, operand, filled.
  - If i_filled=0 and cdb_valid and cdb tag==operand tag in the same cycle, the entry is stored filled with the cdb value.
- Snoop: every cycle, each unfilled valid entry whose tag matches a valid cdb captures cdb value and sets filled.
- Queue: circular, wr/rd pointers plus count.
  - i_ready = (count != DEPTH).
  - Simultaneous enqueue and dequeue while full is not allowed; i_ready stays low when full.
  - Pointers wrap modulo DEPTH.
- FSM, acting on the head entry only:
  - IDLE -> WAIT when queue is non-empty.
  - WAIT -> XFER when rob_head_valid && rob_head==head.rob_id && (opcode==I_IN || head.filled).
  - XFER, I_OUT: io_o_valid=1, io_o_data=value[7:0], held stable until io_o_ready. On handshake, result=0 -> BCAST.
  - XFER, I_IN: io_i_ready=1. On io_i_valid, result = zero-extended io_i_data -> BCAST.
  - BCAST: o_valid=1, o_cdb={rob_id,result}, held until o_ready. Then dequeue -> IDLE if the queue will be empty, else WAIT.
- Latency: dispatch to io request is at least 2 cycles (enqueue, WAIT check). Each handshake adds at least 1 cycle; CDB broadcast adds at least 1 cycle.
- Own broadcast: o_cdb is also observed via cdb input. Entries must not match their own rob_id (operand tags never equal a live own id).
- io and o_valid outputs are registered; no combinational path from io_*_ready to io_*_valid.
- Reset mid-transfer: queue is flushed and handshake outputs drop immediately; no partial byte is retained.
- Width: operand uses only the low 8 bits for output. Input result upper DATA_W-8 bits are 0.

Decomposition:
- fcpu_pkg gets:
  - I_IN and I_OUT opcode constants.
  - io_entry_t struct {rob_id, opcode, tag, value, filled}.
  - io_state_t enum {IDLE, WAIT, XFER, BCAST}.
  - CDB_W reused from fcpu_pkg.
- One sub-module, io_queue: parameterised circular buffer with per-entry CDB snoop ports and head read-out. io_unit holds the FSM and handshakes.

Test Plan:
- I_OUT id=3, filled value 0x141, rob_head=3, io_o_ready=1 -> io_o_data=0x41 one transfer; o_cdb={3,0} with o_valid until o_ready.
- I_IN id=5, rob_head=5, io_i_valid asserted 4 cycles later with 0x7E -> io_i_ready held high until then; o_cdb={5,0x0000007E}.
- I_OUT id=2 unfilled with tag 9; cdb {9,0x55} two cycles later -> io_o_data=0x55. Repeat with the cdb match on the enqueue cycle -> same result.
- I_OUT id=6 filled, rob_head=4 for 10 cycles then 6 -> no io_o_valid until rob_head==6.
- Enqueue 4 ops with io_o_ready=0 -> i_ready=0 after the 4th. Release io_o_ready -> bytes emitted in dispatch order, i_ready reasserts after the first dequeue. Pointers wrap on a further 4 ops.
- nrst low during XFER with io_o_valid=1 -> io_o_valid=0 and i_ready=1 asynchronously; no result broadcast after release.
